unary_multiply_two_bounds: RTL and testbench

- Serial unary (rate-coded) doubler with saturation. Consumes an INPUT_WIDTH-bit unary stream with value A = ones/INPUT_WIDTH and produces an INPUT_WIDTH-bit stream with value Y = min(2A, 1).
- It is the inverse companion of the unary halving unit and uses the same ready/valid bit-serial convention.
- Output bits are emitted early, before the input completes, using running lower and upper bounds on the final result.
- Single-shot per operand; re-armed by clear or reset.

---
 rtl/unary_pkg.sv | 18 +
 rtl/unary_double_bounds.sv | 66 ++++++
 rtl/unary_multiply_two_bounds.sv | 99 +++++++++
 tb/tb_unary_multiply_two_bounds.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary (rate-coded) arithmetic blocks.
package unary_pkg;

  // Bits needed to hold a count from 0 up to and including width.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Per-cycle output decision of the early-emitting doubler.
  typedef enum logic [2:0] {
    DEC_STALL,
    DEC_FORCE1,
    DEC_FORCE0,
    DEC_SPEC1,
    DEC_SPEC0
  } decision_t;

endpackage

// File: rtl/unary_double_bounds.sv
// Combinational bound tracker for the unary doubler: derives the running
// lower/upper bounds on the final output-ones count and picks what to emit.
module unary_double_bounds
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = count_width(INPUT_WIDTH),
  parameter int EPSILON     = 0
) (
  input  logic [COUNT_WIDTH-1:0] a_count,
  input  logic [COUNT_WIDTH-1:0] a_ones,
  input  logic [COUNT_WIDTH-1:0] y_count,
  input  logic [COUNT_WIDTH-1:0] y_ones,
  output logic [COUNT_WIDTH:0]   yl,
  output logic [COUNT_WIDTH:0]   yu,
  output decision_t              decision
);

  localparam int BW = COUNT_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] W_C = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [BW-1:0]          W_B = BW'(INPUT_WIDTH);
  // A tolerance wider than the stream is equivalent to the full stream.
  localparam int EPS2_SAT = (2 * EPSILON > INPUT_WIDTH) ? INPUT_WIDTH : 2 * EPSILON;
  localparam logic [BW-1:0]          EPS2 = BW'(EPS2_SAT);

  // Best case remaining ones on the input: what we have plus every unseen bit.
  // Never exceeds W, so it fits in COUNT_WIDTH bits.
  logic [COUNT_WIDTH-1:0] head;
  // Ones the output could still reach if every remaining slot were a one.
  logic [COUNT_WIDTH-1:0] ones_reach;
  logic [BW-1:0]          twice_o;
  logic [BW-1:0]          twice_head;
  logic [BW-1:0]          spread;
  logic [BW-1:0]          target;
  logic [BW:0]            bound_sum;

  // Bounds, speculation midpoint and the prioritised emit decision.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    decision   = DEC_STALL;
    head       = a_ones + (W_C - a_count);
    twice_o    = {a_ones, 1'b0};
    twice_head = {head, 1'b0};
    yl         = (twice_o > W_B) ? W_B : twice_o;
    yu         = (twice_head > W_B) ? W_B : twice_head;
    ones_reach = y_ones + (W_C - y_count);
    spread     = yu - yl;
    bound_sum  = {1'b0, yl} + {1'b0, yu};
    target     = bound_sum[BW:1];

    if ((a_count != '0) && (y_count < W_C)) begin
      if ({1'b0, ones_reach} <= yl) begin
        // Even all-ones from here on only just meets the lower bound.
        decision = DEC_FORCE1;
      end else if ({1'b0, y_ones} >= yu) begin
        // Upper bound already met: everything left must be zero.
        decision = DEC_FORCE0;
      end else if (spread <= EPS2) begin
        // Bounds tight enough: steer towards their midpoint.
        decision = ({1'b0, y_ones} < target) ? DEC_SPEC1 : DEC_SPEC0;
      end
    end
  end

endmodule

// File: rtl/unary_multiply_two_bounds.sv
// Bit-serial unary doubler with saturation, Y = min(2A, 1). Output bits are
// emitted as soon as running bounds on the final result make them certain
// (or close enough, under EPSILON), so output overlaps input.
module unary_multiply_two_bounds
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = count_width(INPUT_WIDTH),
  parameter int EPSILON     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic a,
  input  logic ready,
  output logic valid,
  output logic y,
  output logic done
);

  localparam logic [COUNT_WIDTH-1:0] W_C = COUNT_WIDTH'(INPUT_WIDTH);

  logic [COUNT_WIDTH-1:0] a_count;
  logic [COUNT_WIDTH-1:0] a_ones;
  logic [COUNT_WIDTH-1:0] y_count;
  logic [COUNT_WIDTH-1:0] y_ones;
  logic [COUNT_WIDTH:0]   yl;
  logic [COUNT_WIDTH:0]   yu;
  decision_t              decision;

  unary_double_bounds #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .EPSILON    (EPSILON)
  ) u_bounds (
    .a_count (a_count),
    .a_ones  (a_ones),
    .y_count (y_count),
    .y_ones  (y_ones),
    .yl      (yl),
    .yu      (yu),
    .decision(decision)
  );

  // Input acceptance, output emission and completion; accept and emit may
  // both happen on the same edge since both read pre-edge counts.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (!reset) begin
      a_count <= '0;
      a_ones  <= '0;
      y_count <= '0;
      y_ones  <= '0;
      valid   <= 1'b0;
      y       <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      a_count <= '0;
      a_ones  <= '0;
      y_count <= '0;
      y_ones  <= '0;
      valid   <= 1'b0;
      y       <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (ready && (a_count < W_C)) begin
        a_count <= a_count + 1'b1;
        a_ones  <= a_ones + COUNT_WIDTH'(a);
      end

      if (y_count == W_C) begin
        valid <= 1'b0;
        y     <= 1'b0;
        done  <= 1'b1;
      end else begin
        unique case (decision)
          DEC_FORCE1, DEC_SPEC1: begin
            y       <= 1'b1;
            valid   <= 1'b1;
            y_ones  <= y_ones + 1'b1;
            y_count <= y_count + 1'b1;
          end
          DEC_FORCE0, DEC_SPEC0: begin
            y       <= 1'b0;
            valid   <= 1'b1;
            y_count <= y_count + 1'b1;
          end
          default: valid <= 1'b0;
        endcase
      end
    end
  end

  // The lower bound can never pass the upper bound; a violation means the
  // counters have become inconsistent.
  bounds_ordered : assert property (@(posedge clk) disable iff (!reset) yl <= yu);

endmodule

// File: tb/tb_unary_multiply_two_bounds.sv
// Bench for the unary doubler: an exact (EPSILON=0) and a speculative
// (EPSILON=2) instance run on the same stimulus, each checked against its own
// integer model of the bound rules through a scoreboard of timed output bits.
module tb_unary_multiply_two_bounds;

  localparam int W = 8;

  typedef struct {
    logic bit_y;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic a;
  logic ready;
  logic valid0, y0, done0;
  logic valid2, y2, done2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t sb[2][$];
  int   mk[2], mo[2], myc[2], myo[2];
  bit   mdone[2];
  int   eps_of[2] = '{0, 2};

  int         ones_out[2];
  int         valid_cnt[2];
  int         first_valid[2];
  logic [7:0] seq_out[2];

  always #5 clk = ~clk;

  unary_multiply_two_bounds #(.INPUT_WIDTH(W), .EPSILON(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .a(a), .ready(ready),
    .valid(valid0), .y(y0), .done(done0)
  );

  unary_multiply_two_bounds #(.INPUT_WIDTH(W), .EPSILON(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .a(a), .ready(ready),
    .valid(valid2), .y(y2), .done(done2)
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mk[i] = 0; mo[i] = 0; myc[i] = 0; myo[i] = 0; mdone[i] = 1'b0;
      sb[i].delete();
    end
  endfunction

  // One clock edge of the bound rules, from pre-edge state.
  function automatic void model_step(int i, logic abit, logic rdy, logic clr);
    int k, o, yc, yo, lo, hi, emit;
    exp_t e;
    k = mk[i]; o = mo[i]; yc = myc[i]; yo = myo[i];
    if (clr) begin
      mk[i] = 0; mo[i] = 0; myc[i] = 0; myo[i] = 0; mdone[i] = 1'b0;
      return;
    end
    emit = -1;
    if (k >= 1 && yc < W) begin
      lo = (2 * o < W) ? 2 * o : W;
      hi = (2 * (o + W - k) < W) ? 2 * (o + W - k) : W;
      if (yo + (W - yc) <= lo) emit = 1;
      else if (yo >= hi) emit = 0;
      else if (hi - lo <= 2 * eps_of[i]) emit = (yo < (lo + hi) / 2) ? 1 : 0;
    end
    if (yc == W) mdone[i] = 1'b1;
    if (rdy && k < W) begin
      mk[i] = k + 1;
      mo[i] = o + int'(abit);
    end
    if (emit >= 0) begin
      myc[i] = yc + 1;
      if (emit == 1) myo[i] = yo + 1;
      e.bit_y = emit[0];
      e.cyc   = cyc + 1;
      sb[i].push_back(e);
    end
  endfunction

  task automatic check_out(input int i, input logic v, input logic yb, input logic d);
    exp_t e;
    logic exp_valid;
    exp_valid = (sb[i].size() > 0 && sb[i][0].cyc == cyc);
    total++;
    if (v !== exp_valid) begin
      bad++;
      $display("FAIL valid inst=%0d cyc=%0d got=%b expected=%b", i, cyc, v, exp_valid);
    end
    if (exp_valid) begin
      e = sb[i].pop_front();
      if (v === 1'b1) begin
        total++;
        if (yb !== e.bit_y) begin
          bad++;
          $display("FAIL y_bit inst=%0d cyc=%0d got=%b expected=%b", i, cyc, yb, e.bit_y);
        end
      end
    end
    if (v === 1'b1) begin
      valid_cnt[i]++;
      if (yb === 1'b1) ones_out[i]++;
      if (first_valid[i] < 0) first_valid[i] = cyc;
      seq_out[i] = {seq_out[i][6:0], yb};
    end
    total++;
    if (d !== mdone[i]) begin
      bad++;
      $display("FAIL done inst=%0d cyc=%0d got=%b expected=%b", i, cyc, d, mdone[i]);
    end
  endtask

  // Drive one cycle of inputs, advance both models, check after the edge.
  task automatic step(input logic abit, input logic rdy, input logic clr);
    a = abit; ready = rdy; clear = clr;
    model_step(0, abit, rdy, clr);
    model_step(1, abit, rdy, clr);
    @(posedge clk);
    cyc++;
    #1;
    check_out(0, valid0, y0, done0);
    check_out(1, valid2, y2, done2);
  endtask

  task automatic rearm();
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Feed W bits MSB first with 'gap' idle (ready low) cycles between them,
  // then keep ready high until both models report completion.
  task automatic run_stream(input logic [7:0] bits, input int gap, output int start);
    int n;
    start = cyc;
    for (int i = 0; i < 2; i++) begin
      ones_out[i] = 0; valid_cnt[i] = 0; first_valid[i] = -1; seq_out[i] = '0;
    end
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat (gap) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(bits[W-1-i], 1'b1, 1'b0);
    end
    n = 0;
    while (!(mdone[0] && mdone[1]) && n < 40) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n++;
    end
    total++;
    if (!(mdone[0] && mdone[1])) begin
      bad++;
      $display("FAIL completion_timeout cyc=%0d got not done expected done within 40 cycles", cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic check_outputs_low(input string name);
    total++;
    if ({valid0, y0, done0, valid2, y2, done2} !== 6'b0) begin
      bad++;
      $display("FAIL %s got=%b expected=000000", name, {valid0, y0, done0, valid2, y2, done2});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; a = 1'b0; ready = 1'b0;
    model_reset();
    #12;
    check_outputs_low("reset_outputs");
    check_int("reset_a_count", int'(dut0.a_count), 0);
    check_int("reset_y_count", int'(dut2.y_count), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ones_first();
    int start;
    run_stream(8'b11110000, 0, start);
    check_int("ones_first_first_valid", first_valid[0], start + 5);
    check_int("ones_first_ones", ones_out[0], 8);
    check_int("ones_first_seq", int'(seq_out[0]), 8'hFF);
    check_int("ones_first_pulses", valid_cnt[0], 8);
    rearm();
  endtask

  task automatic test_all_zero();
    int start;
    run_stream(8'b00000000, 0, start);
    check_int("all_zero_first_valid", first_valid[0], start + 9);
    check_int("all_zero_ones", ones_out[0], 0);
    check_int("all_zero_pulses", valid_cnt[0], 8);
    rearm();
  endtask

  task automatic test_single_one();
    int start;
    run_stream(8'b10000000, 0, start);
    check_int("single_one_seq", int'(seq_out[0]), 8'b11000000);
    check_int("single_one_ones", ones_out[0], 2);
    check_int("single_one_eps2_ones", ones_out[1], 2);
    rearm();
  endtask

  task automatic test_ready_gaps();
    int start;
    run_stream(8'b10101010, 3, start);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    check_int("gaps_ones", ones_out[0], 8);
    check_int("gaps_a_count", int'(dut0.a_count), 8);
    check_int("gaps_a_ones", int'(dut2.a_ones), 4);
    rearm();
  endtask

  task automatic test_clear();
    int start;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_int("clear_a_count", int'(dut0.a_count), 0);
    check_int("clear_a_ones", int'(dut0.a_ones), 0);
    check_int("clear_y_count", int'(dut2.y_count), 0);
    check_int("clear_y_ones", int'(dut2.y_ones), 0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    run_stream(8'hFF, 0, start);
    check_int("clear_rerun_ones", ones_out[0], 8);
    check_int("clear_rerun_eps2_ones", ones_out[1], 8);
    // Async reset with done high.
    #2 reset = 1'b0;
    #1 check_outputs_low("reset_after_done");
    model_reset();
    #1 reset = 1'b1;
    // Async reset in the middle of emission.
    repeat (6) step(1'b1, 1'b1, 1'b0);
    check_int("pre_reset_valid", int'(valid0), 1);
    #2 reset = 1'b0;
    #1 check_outputs_low("reset_mid_emission");
    model_reset();
    #1 reset = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random_eps2();
    int start, ones_in, exact, diff;
    logic [7:0] bits;
    for (int t = 0; t < 200; t++) begin
      bits = 8'($urandom);
      run_stream(bits, $urandom_range(0, 1), start);
      ones_in = $countones(bits);
      exact   = (2 * ones_in < W) ? 2 * ones_in : W;
      diff    = ones_out[1] - exact;
      if (diff < 0) diff = -diff;
      check_int("rand_eps0_exact", ones_out[0], exact);
      total++;
      if (diff > 2) begin
        bad++;
        $display("FAIL rand_eps2_error trial=%0d got=%0d expected=%0d+-2", t, ones_out[1], exact);
      end
      check_int("rand_eps2_pulses", valid_cnt[1], 8);
      total++;
      if (first_valid[1] > first_valid[0]) begin
        bad++;
        $display("FAIL rand_first_valid trial=%0d got=%0d expected<=%0d", t, first_valid[1], first_valid[0]);
      end
      rearm();
    end
  endtask

  initial begin
    test_reset();
    test_ones_first();
    test_all_zero();
    test_single_one();
    test_ready_gaps();
    test_clear();
    test_random_eps2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
